fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch sequencer that feeds the control unit its instruction word and acts on the control unit's branch decision. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and presents each fetched word on `I` for one cycle. One cycle later it samples `PCSel` and advances the PC to `pc+4` or to the branch target. Misaligned targets are trapped.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_req` output 1: read request to instruction memory.
- `imem_addr` output 32: word address of the read; equals `pc`.
- `imem_ack` input 1: memory has `imem_rdata` valid this cycle.
- `imem_rdata` input 32: instruction word from memory.
- `I` output 32: instruction word presented to the control unit.
- `I_valid` output 1: `I` is new this cycle.
- `pc` output 32: address of the instruction held in `I`.
- `PCSel` input 1: registered branch-taken decision from the control unit.
- `br_target` input 32: branch target from the datapath; sampled together with `PCSel`.
- `stall` input 1: freeze the sequencer in ISSUE/RESOLVE.
- `fault` output 1: sticky misaligned-target flag.

## Operation
- FSM states: IDLE, FETCH, ISSUE, RESOLVE, FAULT.
- IDLE → FETCH unconditionally, after one cycle.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, both stable until ack.
  - On `imem_ack`=1 at the edge: `I`<=`imem_rdata`, go to ISSUE.
  - Otherwise stay in FETCH.
- ISSUE:
  - `I_valid`=1; the control unit registers its decode at this edge.
  - `stall`=1: stay in ISSUE, `I_valid` held, `I` unchanged.
  - Otherwise go to RESOLVE.
- RESOLVE:
  - `PCSel` and `br_target` are sampled at this edge.
  - `stall`=1: stay in RESOLVE, no PC change.
  - `PCSel`=0: `pc`<=`pc+4`, go to FETCH.
  - `PCSel`=1 with `br_target[1:0]`==0: `pc`<=`br_target`, go to FETCH.
  - `PCSel`=1 with `br_target[1:0]`!=0: `pc` unchanged, `fault`<=1, go to FAULT.
- FAULT: terminal. `imem_req`=0, `I_valid`=0, `fault`=1 until `rst`.
- Arithmetic: `pc+4` is 32-bit and wraps modulo 2^32. 32'hFFFF_FFFC + 4 = 32'h0000_0000; no flag.
- `imem_ack` outside FETCH is ignored; stale data is never latched.
- `imem_rdata` is only sampled in FETCH on ack.

## Timing
- Reset values: state IDLE, `pc`=`RESET_PC`, `I`=0, `I_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, `fault`=0.
- `rst` wins over every other input at the same edge, including an ack arriving in that cycle.
- First request: `imem_req` rises 1 cycle after `rst` falls.
- Zero-wait memory (ack in the first FETCH cycle): FETCH, ISSUE, RESOLVE take 1 cycle each, so 3 cycles per instruction.
- Each memory wait cycle adds 1 cycle.
- `I_valid` is high exactly one cycle per instruction when unstalled.
- `pc` and `I` change only on the ack edge or the RESOLVE edge.
- Reset mid-fetch: `imem_req` drops the cycle after the reset edge. Memory must tolerate an abandoned request.
- `stall` asserted in FETCH has no effect; the outstanding request completes.

## Test plan
- Reset with `RESET_PC`=32'h100 and zero-wait memory returning 32'h00000033 → `imem_addr` 32'h100, then 32'h104, then 32'h108. `I_valid` pulses every 3rd cycle.
- Ack delayed 4 cycles → `imem_req` high and `imem_addr` stable for 5 cycles. `I` updates only on the ack edge. An extra ack injected in ISSUE is ignored.
- RESOLVE with `PCSel`=1, `br_target`=32'h200 → next `imem_addr` is 32'h200 and `pc` of the next `I` is 32'h200. With `PCSel`=0 → 32'h104.
- `stall` held 3 cycles in ISSUE, then 2 cycles in RESOLVE → `I_valid` high for 4 cycles total. No PC change until the first unstalled RESOLVE edge.
- `PCSel`=1 with `br_target`=32'h202 → `fault`=1 from the next cycle. No further `imem_req`. `rst` clears `fault` and refetches from `RESET_PC`.
- `RESET_PC`=32'hFFFF_FFFC, sequential fetch → second `imem_addr` is 32'h0. `rst` asserted during a pending fetch → `imem_req`=0 the next cycle, and no `I_valid` for the abandoned word.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch sequencer, instruction memory and the control unit.
// master = fetch_unit side, slave = memory / control-unit side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] I;
  logic        I_valid;
  logic [31:0] pc;
  logic        PCSel;
  logic [31:0] br_target;
  logic        stall;
  logic        fault;

  modport master (
    output imem_req, imem_addr, I, I_valid, pc, fault,
    input  imem_ack, imem_rdata, PCSel, br_target, stall
  );

  modport slave (
    input  imem_req, imem_addr, I, I_valid, pc, fault,
    output imem_ack, imem_rdata, PCSel, br_target, stall
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, fetches one word per instruction
// over a req/ack handshake, presents it for one cycle, then follows PCSel.
// Misaligned branch targets park the unit in a sticky FAULT state.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_RESOLVE = 3'd3,
    S_FAULT   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_q, fault_d;

  logic        resolve_go;
  logic        target_misaligned;

  assign resolve_go        = (state_q == S_RESOLVE) && !bus.stall;
  assign target_misaligned = (bus.br_target[1:0] != 2'b00);

  // State register: reset dominates every other input, including a same-edge ack.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  // Next-state and datapath update: I only on the ack edge, PC only on an unstalled RESOLVE.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!bus.stall) state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (resolve_go) begin
          if (!bus.PCSel) begin
            pc_d    = pc_q + 32'd4;   // wraps modulo 2^32 by construction
            state_d = S_FETCH;
          end else if (!target_misaligned) begin
            pc_d    = bus.br_target;
            state_d = S_FETCH;
          end else begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: request only while fetching, valid only while issuing.
  always_comb begin
    bus.imem_req  = (state_q == S_FETCH);
    bus.I_valid   = (state_q == S_ISSUE);
    bus.imem_addr = pc_q;
    bus.pc        = pc_q;
    bus.I         = instr_q;
    bus.fault     = fault_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances, one with RESET_PC=0x100 for
// sequencing/branch/stall/fault, one with RESET_PC=0xFFFFFFFC for wrap and
// reset-during-fetch.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   vectors    = 0;
  int   miscompares = 0;

  fetch_unit_if bus_a ();
  fetch_unit_if bus_b ();

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic req, input logic [31:0] addr,
                       input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                       input logic flt);
    chk({tag, ".req"},   32'(bus_a.imem_req),  32'(req));
    chk({tag, ".addr"},  bus_a.imem_addr,      addr);
    chk({tag, ".ivld"},  32'(bus_a.I_valid),   32'(iv));
    chk({tag, ".I"},     bus_a.I,              instr);
    chk({tag, ".pc"},    bus_a.pc,             pc);
    chk({tag, ".fault"}, 32'(bus_a.fault),     32'(flt));
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.imem_ack = 1'b0; bus_a.imem_rdata = '0; bus_a.PCSel = 1'b0;
    bus_a.br_target = '0;  bus_a.stall = 1'b0;
    bus_b.imem_ack = 1'b0; bus_b.imem_rdata = '0; bus_b.PCSel = 1'b0;
    bus_b.br_target = '0;  bus_b.stall = 1'b0;

    // ---- A: reset state ----
    tick(); tick();
    chk_a("a_reset", 1'b0, 32'h100, 1'b0, 32'h0, 32'h100, 1'b0);

    // ---- A: zero-wait sequential fetch, ack held high throughout ----
    rst_a = 1'b0;
    bus_a.imem_ack = 1'b1; bus_a.imem_rdata = 32'h0000_0033;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk($sformatf("a_seq%0d.req", c),  32'(bus_a.imem_req), 32'((c % 3) == 1));
      chk($sformatf("a_seq%0d.ivld", c), 32'(bus_a.I_valid),  32'((c % 3) == 2));
      chk($sformatf("a_seq%0d.addr", c), bus_a.imem_addr, 32'h100 + 32'(4 * ((c - 1) / 3)));
    end
    // now in RESOLVE of the word at 0x108

    // ---- A: ack delayed, stale rdata must not latch ----
    bus_a.imem_ack = 1'b0; bus_a.imem_rdata = 32'hBAD0_0000;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_a($sformatf("a_wait%0d", c), 1'b1, 32'h10C, 1'b0, 32'h33, 32'h10C, 1'b0);
    end
    bus_a.imem_ack = 1'b1; bus_a.imem_rdata = 32'hAAAA_0001;
    tick();
    chk_a("a_ackedge", 1'b0, 32'h10C, 1'b1, 32'hAAAA_0001, 32'h10C, 1'b0);

    // extra ack in ISSUE ignored; branch to 0x200 prepared for RESOLVE
    bus_a.imem_rdata = 32'h5555_5555;
    bus_a.PCSel = 1'b1; bus_a.br_target = 32'h200;
    tick();
    chk_a("a_stray_ack", 1'b0, 32'h10C, 1'b0, 32'hAAAA_0001, 32'h10C, 1'b0);
    bus_a.imem_ack = 1'b0;
    tick();
    chk_a("a_branch", 1'b1, 32'h200, 1'b0, 32'hAAAA_0001, 32'h200, 1'b0);
    bus_a.PCSel = 1'b0; bus_a.br_target = 32'h0;
    bus_a.imem_ack = 1'b1; bus_a.imem_rdata = 32'h0000_0013;
    tick();
    chk_a("a_br_issue", 1'b0, 32'h200, 1'b1, 32'h13, 32'h200, 1'b0);

    // ---- A: stall 3 edges in ISSUE, 2 edges in RESOLVE ----
    bus_a.imem_ack = 1'b0; bus_a.stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_a($sformatf("a_stall_iss%0d", c), 1'b0, 32'h200, 1'b1, 32'h13, 32'h200, 1'b0);
    end
    bus_a.stall = 1'b0;
    tick();
    chk_a("a_resolve", 1'b0, 32'h200, 1'b0, 32'h13, 32'h200, 1'b0);
    bus_a.stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk_a($sformatf("a_stall_res%0d", c), 1'b0, 32'h200, 1'b0, 32'h13, 32'h200, 1'b0);
    end
    bus_a.stall = 1'b0;
    tick();
    chk_a("a_unstall", 1'b1, 32'h204, 1'b0, 32'h13, 32'h204, 1'b0);

    // ---- A: stall during FETCH has no effect ----
    bus_a.stall = 1'b1; bus_a.imem_ack = 1'b1; bus_a.imem_rdata = 32'h0000_0067;
    tick();
    chk_a("a_fetch_stall", 1'b0, 32'h204, 1'b1, 32'h67, 32'h204, 1'b0);
    bus_a.stall = 1'b0; bus_a.imem_ack = 1'b0;
    tick();
    chk_a("a_res2", 1'b0, 32'h204, 1'b0, 32'h67, 32'h204, 1'b0);

    // ---- A: misaligned target traps ----
    bus_a.PCSel = 1'b1; bus_a.br_target = 32'h202;
    tick();
    chk_a("a_fault", 1'b0, 32'h204, 1'b0, 32'h67, 32'h204, 1'b1);
    bus_a.PCSel = 1'b0; bus_a.br_target = 32'h0;
    bus_a.imem_ack = 1'b1; bus_a.imem_rdata = 32'h0000_0777;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk_a($sformatf("a_fault_hold%0d", c), 1'b0, 32'h204, 1'b0, 32'h67, 32'h204, 1'b1);
    end
    rst_a = 1'b1; bus_a.imem_ack = 1'b0;
    tick();
    chk_a("a_fault_rst", 1'b0, 32'h100, 1'b0, 32'h0, 32'h100, 1'b0);
    rst_a = 1'b0;
    tick();
    chk_a("a_refetch", 1'b1, 32'h100, 1'b0, 32'h0, 32'h100, 1'b0);
    rst_a = 1'b1;

    // ---- B: PC wrap and reset during a pending fetch ----
    rst_b = 1'b0;
    bus_b.imem_ack = 1'b1; bus_b.imem_rdata = 32'h0000_0011;
    tick();
    chk("b_first.req",  32'(bus_b.imem_req), 32'd1);
    chk("b_first.addr", bus_b.imem_addr,     32'hFFFF_FFFC);
    tick();
    chk("b_issue.ivld", 32'(bus_b.I_valid),  32'd1);
    chk("b_issue.I",    bus_b.I,             32'h11);
    chk("b_issue.pc",   bus_b.pc,            32'hFFFF_FFFC);
    bus_b.imem_ack = 1'b0;
    tick();
    tick();
    chk("b_wrap.req",   32'(bus_b.imem_req), 32'd1);
    chk("b_wrap.addr",  bus_b.imem_addr,     32'h0);
    tick();
    chk("b_pend.req",   32'(bus_b.imem_req), 32'd1);
    // reset and ack at the same edge: reset wins
    rst_b = 1'b1; bus_b.imem_ack = 1'b1; bus_b.imem_rdata = 32'h0000_0099;
    tick();
    chk("b_rst.req",    32'(bus_b.imem_req), 32'd0);
    chk("b_rst.ivld",   32'(bus_b.I_valid),  32'd0);
    chk("b_rst.I",      bus_b.I,             32'h0);
    chk("b_rst.pc",     bus_b.pc,            32'hFFFF_FFFC);
    bus_b.imem_ack = 1'b0;
    tick();
    chk("b_rst2.ivld",  32'(bus_b.I_valid),  32'd0);
    rst_b = 1'b0;
    tick();
    chk("b_rel.req",    32'(bus_b.imem_req), 32'd1);
    chk("b_rel.ivld",   32'(bus_b.I_valid),  32'd0);
    chk("b_rel.addr",   bus_b.imem_addr,     32'hFFFF_FFFC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
